// File: rtl/regfile_pkg.sv
// Shared sizing constants for the 2-read / 1-write register file.
//   REG_WIDTH  : data width of one register
//   REG_COUNT  : number of architectural registers
//   REG_ADDR_W : register address width (log2 of REG_COUNT)
//   ZERO_REG   : index of the hardwired-zero register
package regfile_pkg;

  localparam int unsigned REG_WIDTH  = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ZERO_REG   = 0;

endpackage : regfile_pkg

// File: rtl/mux32.sv
// 32:1 multiplexer of WIDTH-bit words.
//   sel  : 5-bit input select
//   din  : 32 input words, din[k] selected when sel == k
//   dout : selected word (combinational)
module mux32
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = REG_WIDTH
) (
  input  logic [4:0]            sel,
  input  logic [31:0][WIDTH-1:0] din,
  output logic [WIDTH-1:0]      dout
);

  assign dout = din[sel];

endmodule : mux32

// File: rtl/register32_en.sv
// WIDTH-bit storage register with load enable.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high clear
//   en    : load enable; d is captured on the rising edge when high
//   d     : load data
//   q     : stored value
module register32_en
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = REG_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset dominates, so an edge seen while reset is high never loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : register32_en

// File: rtl/regfile_2r1w.sv
// 32 x 32-bit register file, two combinational read ports, one write port.
//   clk           : rising-edge clock
//   reset         : asynchronous, active-high; clears every register
//   RegWrite      : write enable for this cycle
//   WriteRegister : write address
//   WriteData     : write data
//   ReadRegister1 : read port 1 address
//   ReadRegister2 : read port 2 address
//   ReadData1     : contents of ReadRegister1 (combinational, no bypass)
//   ReadData2     : contents of ReadRegister2 (combinational, no bypass)
// DEPTH is fixed at 32 and ADDR_W at 5 to match the 32:1 read multiplexers.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = REG_WIDTH,
  parameter int unsigned DEPTH  = REG_COUNT,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2
);

  logic [DEPTH-1:0]            wr_en_c;
  logic [DEPTH-1:0][WIDTH-1:0] reg_q;

  // One-hot write decode; all zero when RegWrite is low.
  assign wr_en_c = DEPTH'(RegWrite) << WriteRegister;

  // Register 0 is a tie-off, so a write to address 0 simply has no target.
  assign reg_q[ZERO_REG] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    register32_en #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (wr_en_c[i]),
      .d     (WriteData),
      .q     (reg_q[i])
    );
  end

  // Independent read ports; same-cycle writes are not forwarded.
  mux32 #(
    .WIDTH (WIDTH)
  ) u_rd1_mux (
    .sel  (ReadRegister1),
    .din  (reg_q),
    .dout (ReadData1)
  );

  mux32 #(
    .WIDTH (WIDTH)
  ) u_rd2_mux (
    .sel  (ReadRegister2),
    .din  (reg_q),
    .dout (ReadData2)
  );

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: vector table plus hand sequences
// for reset and the walking-write decoder check.
module tb_regfile_2r1w;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  regfile_2r1w dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] pre1;
    logic [31:0] pre2;
    logic [31:0] post1;
    logic [31:0] post2;
  } vec_t;

  logic [31:0] model [32];

  task automatic sb_push(input string n, input logic [31:0] e);
    sb_t s;
    s.name = n;
    s.exp  = e;
    sb_q.push_back(s);
  endtask

  task automatic sb_check(input logic [31:0] act);
    sb_t s;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      s = sb_q.pop_front();
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", s.name, act, s.exp);
      end
    end
  endtask

  // Drive both read addresses, queue expectations, then sample both ports.
  task automatic read_chk(input string n, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [31:0] e1, input logic [31:0] e2);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    sb_push($sformatf("%s rd1[%0d]", n, a1), e1);
    sb_push($sformatf("%s rd2[%0d]", n, a2), e2);
    #1;
    sb_check(ReadData1);
    sb_check(ReadData2);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 32; k++) model[k] = '0;
  endtask

  vec_t vecs [6];

  initial begin
    clk           = 1'b0;
    reset         = 1'b1;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    clear_model();

    vecs[0] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'h0,        32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[1] = '{1'b0, 5'd9,  32'h12345678, 5'd9,  5'd7,  32'h0,        32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5};
    vecs[3] = '{1'b1, 5'd31, 32'h00000001, 5'd31, 5'd0,  32'h0,        32'h0,        32'h00000001, 32'h0};
    vecs[4] = '{1'b1, 5'd7,  32'h5A5A5A5A, 5'd7,  5'd31, 32'hA5A5A5A5, 32'h00000001, 32'h5A5A5A5A, 32'h00000001};
    vecs[5] = '{1'b1, 5'd1,  32'hCAFEF00D, 5'd1,  5'd7,  32'h0,        32'h5A5A5A5A, 32'hCAFEF00D, 32'h5A5A5A5A};

    // Power-on reset: everything reads zero.
    repeat (2) @(negedge clk);
    read_chk("por", 5'd5, 5'd26, 32'h0, 32'h0);
    reset = 1'b0;

    // Asynchronous reset clears written data without a clock edge.
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd5;
    WriteData     = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    read_chk("pre_reset", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    reset = 1'b1;
    read_chk("async_reset", 5'd5, 5'd5, 32'h0, 32'h0);
    for (int a = 0; a < 32; a++) begin
      read_chk("reset_all", 5'(a), 5'(31 - a), 32'h0, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Vector table: pre-edge reads show the old value, post-edge the new one.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      RegWrite      = vecs[v].we;
      WriteRegister = vecs[v].wa;
      WriteData     = vecs[v].wd;
      read_chk($sformatf("vec%0d_pre", v), vecs[v].ra1, vecs[v].ra2, vecs[v].pre1, vecs[v].pre2);
      @(posedge clk);
      #1;
      read_chk($sformatf("vec%0d_post", v), vecs[v].ra1, vecs[v].ra2, vecs[v].post1, vecs[v].post2);
    end
    @(negedge clk);
    RegWrite = 1'b0;
    read_chk("untouched", 5'd9, 5'd5, 32'h0, 32'h0);

    // Clear between clock edges before the decoder walk.
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    clear_model();
    read_chk("reset_pulse", 5'd7, 5'd1, 32'h0, 32'h0);

    // Walking writes: each register gets its own value, neighbours untouched.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = 5'(i);
      WriteData     = 32'(i) * 32'h01010101;
      @(posedge clk);
      model[i] = 32'(i) * 32'h01010101;
      #1;
      RegWrite = 1'b0;
      read_chk("walk", 5'(i), 5'(i - 1), model[i], model[i - 1]);
      if (i < 31) read_chk("walk_next", 5'(i + 1), 5'd0, model[i + 1], 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      read_chk("pair", 5'(i), 5'(31 - i), model[i], model[31 - i]);
    end

    // Reset held across a write edge: the write is lost; next edge writes.
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = 32'h33333333;
    #4 reset = 1'b1;
    @(posedge clk);
    clear_model();
    #1;
    read_chk("reset_on_edge", 5'd3, 5'd3, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    read_chk("after_deassert", 5'd3, 5'd4, 32'h33333333, 32'h0);

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_regfile_2r1w
